// File: rtl/nrs_pkg.sv
// Shared constants, state encoding and QPSK level helper
// for the NRS estimation-side reader.
package nrs_pkg;

  localparam int WIDTH_REG     = 16;
  localparam int LINES         = $clog2(WIDTH_REG);
  localparam int NRS_WIDTH_R_I = 16;
  localparam int FRAC          = 14;
  localparam int AMP           = 11585;
  localparam int NUM_SYM       = WIDTH_REG / 2;
  localparam int SYM_W         = $clog2(NUM_SYM);

  typedef enum logic [2:0] {
    IDLE,
    RD_E,
    RD_O,
    CAP,
    OUT,
    ACK,
    WAIT_LOW
  } state_t;

  // Bit 0 maps to +AMP, bit 1 to -AMP (Q1.FRAC).
  function automatic logic signed [NRS_WIDTH_R_I-1:0]
    qpsk_level(input logic b);
    logic signed [NRS_WIDTH_R_I-1:0] a;
    a = NRS_WIDTH_R_I'(AMP);
    return b ? -a : a;
  endfunction

endpackage

// File: rtl/nrs_qpsk_map.sv
// Combinational QPSK mapper: (c_e, c_o) -> (nrs_re, nrs_im).
// Ports: c_e, c_o in; nrs_re, nrs_im signed out.
import nrs_pkg::*;

module nrs_qpsk_map (
  input  logic                            c_e,
  input  logic                            c_o,
  output logic signed [NRS_WIDTH_R_I-1:0] nrs_re,
  output logic signed [NRS_WIDTH_R_I-1:0] nrs_im
);

  assign nrs_re = qpsk_level(c_e);
  assign nrs_im = qpsk_level(c_o);

endmodule

// File: rtl/nrs_est_reader.sv
// Reads one NRS slot bit-pair-wise and streams QPSK symbols.
// Ports: clk/rst, new_frame, NRS_gen_ready, nrs_est/rd_addr_est,
// est_ack, nrs_re/nrs_im/sym_idx/out_valid/out_last, out_ready.
import nrs_pkg::*;

module nrs_est_reader (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            new_frame,
  input  logic                            NRS_gen_ready,
  input  logic                            nrs_est,
  output logic [LINES-1:0]                rd_addr_est,
  output logic                            est_ack,
  output logic signed [NRS_WIDTH_R_I-1:0] nrs_re,
  output logic signed [NRS_WIDTH_R_I-1:0] nrs_im,
  output logic [SYM_W-1:0]                sym_idx,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last
);

  state_t state_q, state_d;

  logic [SYM_W-1:0] m_q, m_d;
  logic             c_e_q;
  logic             reading;
  logic             abort;
  logic             accept;
  logic             last_sym;

  logic signed [NRS_WIDTH_R_I-1:0] map_re;
  logic signed [NRS_WIDTH_R_I-1:0] map_im;

  // The odd bit is still on nrs_est during CAP,
  // so it feeds the mapper directly.
  nrs_qpsk_map u_map (
    .c_e    (c_e_q),
    .c_o    (nrs_est),
    .nrs_re (map_re),
    .nrs_im (map_im)
  );

  assign reading = (state_q == RD_E) ||
                   (state_q == RD_O) ||
                   (state_q == CAP)  ||
                   (state_q == OUT);

  // Losing ready mid-read means the slot is gone.
  assign abort = (state_q != IDLE) &&
                 (new_frame || (reading && !NRS_gen_ready));

  assign accept   = out_valid & out_ready;
  assign last_sym = (m_q == SYM_W'(NUM_SYM - 1));

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    if (abort) begin
      state_d = IDLE;
      m_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (NRS_gen_ready && !new_frame) begin
            state_d = RD_E;
            m_d     = '0;
          end
        end
        RD_E: state_d = RD_O;
        RD_O: state_d = CAP;
        CAP:  state_d = OUT;
        OUT: begin
          if (accept) begin
            if (last_sym) begin
              state_d = ACK;
            end else begin
              state_d = RD_E;
              m_d     = m_q + 1'b1;
            end
          end
        end
        ACK:  state_d = WAIT_LOW;
        WAIT_LOW: begin
          if (!NRS_gen_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      m_q         <= '0;
      c_e_q       <= 1'b0;
      rd_addr_est <= '0;
      est_ack     <= 1'b0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      nrs_re      <= '0;
      nrs_im      <= '0;
      sym_idx     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;

      // Address is registered so it leads nrs_est by one cycle.
      if (state_d == RD_E)
        rd_addr_est <= {m_d, 1'b0};
      else if (state_d == RD_O)
        rd_addr_est <= {m_q, 1'b1};

      if (state_q == RD_O)
        c_e_q <= nrs_est;

      if (state_q == CAP && state_d == OUT) begin
        nrs_re  <= map_re;
        nrs_im  <= map_im;
        sym_idx <= m_q;
      end

      out_valid <= (state_d == OUT);
      out_last  <= (state_d == OUT) &&
                   (m_d == SYM_W'(NUM_SYM - 1));
      est_ack   <= (state_d == ACK);
    end
  end

endmodule

// File: tb/tb_nrs_est_reader.sv
// Scoreboard bench for nrs_est_reader with a behavioural
// register model and randomized words / backpressure.
module tb_nrs_est_reader;
  import nrs_pkg::*;

  localparam int AMP_REF = 11585;

  logic clk = 1'b0;
  logic rst, new_frame, NRS_gen_ready, nrs_est, out_ready;
  logic [LINES-1:0] rd_addr_est;
  logic est_ack, out_valid, out_last;
  logic signed [NRS_WIDTH_R_I-1:0] nrs_re, nrs_im;
  logic [SYM_W-1:0] sym_idx;
  logic [15:0] word;

  int tests = 0;
  int fails = 0;
  int acks_seen = 0;

  typedef struct {
    int re;
    int im;
    int idx;
    int last;
  } exp_t;

  exp_t q[$];

  nrs_est_reader dut (
    .clk           (clk),
    .rst           (rst),
    .new_frame     (new_frame),
    .NRS_gen_ready (NRS_gen_ready),
    .nrs_est       (nrs_est),
    .rd_addr_est   (rd_addr_est),
    .est_ack       (est_ack),
    .nrs_re        (nrs_re),
    .nrs_im        (nrs_im),
    .sym_idx       (sym_idx),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last)
  );

  always #5 clk = ~clk;

  // Generator register: synchronous one-cycle read.
  always @(posedge clk) nrs_est <= word[rd_addr_est];

  task automatic check(input string name, input int act,
                       input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d",
               name, act, req);
    end
  endtask

  task automatic push_slot(input logic [15:0] w);
    exp_t e;
    for (int m = 0; m < 8; m++) begin
      e.re   = w[2*m]   ? -AMP_REF : AMP_REF;
      e.im   = w[2*m+1] ? -AMP_REF : AMP_REF;
      e.idx  = m;
      e.last = (m == 7) ? 1 : 0;
      q.push_back(e);
    end
  endtask

  // Monitor: compares every presented symbol against the queue head.
  bit exp_ack = 1'b0;
  bit prev_valid = 1'b0;
  logic [LINES-1:0] prev_addr = '0;

  always @(negedge clk) begin
    if (est_ack || exp_ack)
      check("est_ack", int'(est_ack), int'(exp_ack));
    if (est_ack) acks_seen++;
    exp_ack = out_valid && out_ready && out_last &&
              !new_frame && !rst && NRS_gen_ready;
    if (out_valid) begin
      if (prev_valid)
        check("addr_hold", int'(rd_addr_est), int'(prev_addr));
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got sym %0d, required none",
                 sym_idx);
      end else begin
        check("nrs_re", int'(nrs_re), q[0].re);
        check("nrs_im", int'(nrs_im), q[0].im);
        check("sym_idx", int'(sym_idx), q[0].idx);
        check("out_last", int'(out_last), q[0].last);
        if (out_ready && !new_frame && !rst && NRS_gen_ready)
          void'(q.pop_front());
      end
    end
    prev_valid = out_valid;
    prev_addr  = rd_addr_est;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: always ready, 1: random ready, 2: hold m3 for 5 cycles
  task automatic run_slot(input logic [15:0] w, input int mode,
                          input bit timing);
    int start;
    int hold;
    bit done;
    start = acks_seen;
    hold  = 0;
    done  = 1'b0;
    word  = w;
    push_slot(w);
    out_ready     = (mode != 1);
    NRS_gen_ready = 1'b1;
    if (timing) begin
      step();
      check("lat_addr_e", int'(rd_addr_est), 0);
      step();
      check("lat_addr_o", int'(rd_addr_est), 1);
      step();
      check("lat_valid_lo", int'(out_valid), 0);
      step();
      check("lat_valid_hi", int'(out_valid), 1);
    end
    for (int i = 0; i < 400; i++) begin
      if (acks_seen != start) begin
        done = 1'b1;
        break;
      end
      if (mode == 1) begin
        out_ready = 1'($urandom_range(0, 1));
      end else if (mode == 2) begin
        if (out_valid && sym_idx == 3 && hold < 5) begin
          out_ready = 1'b0;
          hold++;
        end else begin
          out_ready = 1'b1;
        end
      end else begin
        out_ready = 1'b1;
      end
      step();
    end
    check("slot_done", int'(done), 1);
    check("slot_acks", acks_seen - start, 1);
    if (mode == 2) check("bp_hold", hold, 5);
  endtask

  task automatic drop_ready();
    NRS_gen_ready = 1'b0;
    out_ready     = 1'b0;
    step();
    step();
  endtask

  initial begin
    int a0;
    rst           = 1'b1;
    new_frame     = 1'b0;
    NRS_gen_ready = 1'b0;
    out_ready     = 1'b0;
    word          = '0;
    step();
    step();
    check("rst_addr", int'(rd_addr_est), 0);
    check("rst_ack", int'(est_ack), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_last", int'(out_last), 0);
    check("rst_re", int'(nrs_re), 0);
    check("rst_im", int'(nrs_im), 0);
    check("rst_idx", int'(sym_idx), 0);
    rst = 1'b0;
    step();

    run_slot(16'hA5C3, 0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("wait_low_idle", int'(out_valid), 0);
    end
    drop_ready();

    run_slot(16'hFFFF, 0, 1'b0);
    drop_ready();

    run_slot(16'hA5C3, 2, 1'b0);
    drop_ready();

    // Abort with new_frame while m=4 is presented.
    word = 16'($urandom);
    push_slot(word);
    a0 = acks_seen;
    out_ready     = 1'b0;
    NRS_gen_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (out_valid && sym_idx == 4) break;
      out_ready = out_valid;
      step();
    end
    check("abort_at_m4", int'(sym_idx), 4);
    new_frame = 1'b1;
    out_ready = 1'b0;
    step();
    new_frame = 1'b0;
    check("abort_valid", int'(out_valid), 0);
    q.delete();
    run_slot(word, 0, 1'b0);
    check("abort_acks", acks_seen - a0, 1);
    drop_ready();

    // Reset while in RD_O.
    word = 16'($urandom);
    push_slot(word);
    a0 = acks_seen;
    NRS_gen_ready = 1'b1;
    out_ready     = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    check("mrst_addr", int'(rd_addr_est), 0);
    check("mrst_valid", int'(out_valid), 0);
    check("mrst_re", int'(nrs_re), 0);
    check("mrst_im", int'(nrs_im), 0);
    check("mrst_idx", int'(sym_idx), 0);
    check("mrst_last", int'(out_last), 0);
    check("mrst_ack", int'(est_ack), 0);
    rst = 1'b0;
    q.delete();
    run_slot(word, 0, 1'b0);
    check("mrst_acks", acks_seen - a0, 1);
    drop_ready();

    for (int s = 0; s < 6; s++) begin
      run_slot(16'($urandom), 1, 1'b0);
      drop_ready();
    end

    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
